jtag_core_sequencer: RTL
========================

# jtag_core_sequencer

Core-side JTAG TAP master that drives the MAX 10 internal JTAG atom when core access is enabled. It takes one command at a time (a fixed-width instruction plus an optional data-register payload), claims the TAP via `jtag_core_en`, and bit-bangs `tck_core`/`tms_core`/`tdi_core` from the system clock. It captures `tdo_core` during DR shift. It sits directly upstream of the JTAG atom wrapper and is used for security-mode checks, volatile-key clear and lock/unlock instruction sequences.

## Interface
- `IR_W`, 10: instruction register length in bits.
- `DR_W`, 32: maximum DR payload length in bits.
- `HALF_DIV`, 2: `clk` cycles per TCK half-period; must be ≥1.
- `RTI_CYCLES`, 4: TCK cycles spent in Run-Test/Idle after each command; may be 0.

Ports:
- `clk`  in  1  system clock.
- `srst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  sequencer idle and able to accept a command.
- `cmd_ir`  in  IR_W  instruction, shifted LSB first.
- `cmd_dr_len`  in  $clog2(DR_W+1)  DR bits to shift; 0 means no DR phase.
- `cmd_dr`  in  DR_W  DR payload, shifted LSB first.
- `rsp_valid`  out  1  one-cycle pulse on command completion.
- `rsp_dr`  out  DR_W  captured TDO bits, LSB = first bit shifted out.
- `jtag_core_en`  out  1  core-owns-TAP select to the atom.
- `tck_core`, `tms_core`, `tdi_core`  out  1 each  to the atom.
- `tdo_core`  in  1  from the atom.

## Operation
- A command is accepted when `cmd_valid` and `cmd_ready` are both high on the same cycle.
- On accept, `cmd_ir`, `cmd_dr`, and `min(cmd_dr_len, DR_W)` are registered. `cmd_ready` drops and `jtag_core_en` rises on the next cycle.
- The state machine runs through these states in order:
  - IDLE.
  - TLR: 5 TCK cycles with TMS=1, then 1 cycle with TMS=0, reaching Run-Test/Idle.
  - IR_NAV: TMS sequence 1,1,0,0.
  - IR_SHIFT: IR_W cycles. TDI carries IR bits. TMS=0 except TMS=1 on the last bit.
  - IR_EXIT: TMS sequence 1,0 (Update-IR, then Run-Test/Idle).
  - DR_NAV, DR_SHIFT, DR_EXIT: run only if len>0. DR_NAV is TMS 1,0,0. DR_SHIFT is len cycles, TMS=1 on the last bit. DR_EXIT is TMS 1,0.
  - RTI_WAIT: RTI_CYCLES cycles with TMS=0.
  - DONE, then back to IDLE.
- TDI is 0 outside the shift states.
- In DR_SHIFT, `tdo_core` sampled at TCK rise k is stored into `rsp_dr[k]`. Bits ≥ len are 0.
- In DONE, `rsp_valid` pulses for 1 cycle and `jtag_core_en` drops in the same cycle. `cmd_ready` returns high the following cycle.
- `cmd_valid` during a busy period is ignored; it is not queued.
- `srst` mid-command returns every output to its reset value on the next edge, with no completion pulse.

## Timing
- Reset values:
  - `cmd_ready`=0 while `srst` is high, 1 on the first cycle after release.
  - `rsp_valid`=0, `rsp_dr`=0.
  - `jtag_core_en`=0, `tck_core`=0, `tms_core`=1, `tdi_core`=0.
- TCK idles low. Each TCK cycle is a low half (HALF_DIV clk) followed by a high half (HALF_DIV clk).
- TMS and TDI change only on the clk edge that starts a low half. They are stable across the following rising edge.
- TDO is registered on the clk edge that drives TCK high.
- TCK cycles per command = 6 + (IR_W+6) + (len>0 ? len+5 : 0) + RTI_CYCLES.
- `rsp_valid` fires 1 clk after the last high half ends.
- With defaults and len=0: 26 TCK cycles, 104 clk from the `jtag_core_en` rise to `rsp_valid`.
- `rsp_dr` holds its value until the next accept. It is cleared when the next command is accepted.

## Configuration
- `JTAG_SEQ_TDO_CAPTURE_EN`:
  - Defined: DR_SHIFT captures TDO into `rsp_dr` as described above.
  - Undefined: no capture logic is built and `rsp_dr` is constant 0. Sequencing is unchanged.

## Test plan
- IR-only command: reset release, `cmd_ir`=0x0F2, len=0, defaults.
  - Exactly 26 TCK rises.
  - TMS pattern 1,1,1,1,1,0,1,1,0,0 then IR bits 0,1,0,0,1,1,1,1,0,0 with TMS=1 on bit 9.
  - `rsp_valid` 104 clk after `jtag_core_en` rise; `rsp_dr`=0.
- DR loopback: `tdo_core` tied to `tdi_core` delayed by one TCK, `cmd_dr`=0xA5A5_3C3C, len=32.
  - 63 TCK cycles.
  - `rsp_dr` shows the payload shifted by one bit.
- Length clamp: len=33 with DR_W=32.
  - Behaves identically to len=32.
- Reset mid-command: `srst` asserted during IR_SHIFT.
  - Next cycle: `jtag_core_en`=0, `tms_core`=1, `tck_core`=0, no `rsp_valid`.
  - A new command afterwards completes normally.
- Back-to-back commands: `cmd_valid` held high for two commands.
  - Second accept occurs exactly 1 clk after the first `rsp_valid`.
  - `cmd_valid` asserted while busy is not accepted.
- Capture macro off: rerun the loopback test with `JTAG_SEQ_TDO_CAPTURE_EN` undefined.
  - `rsp_dr`=0; TCK, TMS and TDI waveforms identical to the macro-defined run.

Source files
------------

// File: rtl/jtag_core_sequencer.sv
// Purpose: core-side JTAG TAP master; bit-bangs TCK/TMS/TDI into the MAX 10 JTAG atom for one IR(+DR) command.
// Latency: (12 + IR_W + (len ? len+5 : 0) + RTI_CYCLES) TCK cycles of 2*HALF_DIV clk from accept to rsp_valid.
// Backpressure: one command in flight; cmd_ready low while busy, cmd_valid seen while busy is dropped (not queued).
// Build option: define JTAG_SEQ_TDO_CAPTURE_EN to build DR-shift TDO capture into rsp_dr; otherwise rsp_dr is 0.
module jtag_core_sequencer #(
    parameter int IR_W       = 10,
    parameter int DR_W       = 32,
    parameter int HALF_DIV   = 2,
    parameter int RTI_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [IR_W-1:0]            cmd_ir,
    input  logic [$clog2(DR_W+1)-1:0]  cmd_dr_len,
    input  logic [DR_W-1:0]            cmd_dr,
    output logic                       rsp_valid,
    output logic [DR_W-1:0]            rsp_dr,
    output logic                       jtag_core_en,
    output logic                       tck_core,
    output logic                       tms_core,
    output logic                       tdi_core,
    input  logic                       tdo_core
);
    localparam int LEN_W  = $clog2(DR_W + 1);
    localparam int DIV_W  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam int STEP_W = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TLR,
        S_IR_NAV,
        S_IR_SHIFT,
        S_IR_EXIT,
        S_DR_NAV,
        S_DR_SHIFT,
        S_DR_EXIT,
        S_RTI_WAIT,
        S_DONE
    } state_t;

    // Where the sequence goes once the IR (or DR) phase has returned to Run-Test/Idle.
    localparam state_t POST_DR = (RTI_CYCLES > 0) ? S_RTI_WAIT : S_DONE;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;
    logic                en_q, en_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [IR_W-1:0]     ir_q, ir_d;
    logic [DR_W-1:0]     dr_q, dr_d;
    logic [LEN_W-1:0]    len_q, len_d;

    logic                accept;
    logic                last_half;
    logic                last_step;
    state_t              nxt_state;
    logic [STEP_W-1:0]   nxt_step;
    logic [LEN_W-1:0]    len_clamped;

    // Payload lengths above DR_W are treated as a full-width shift.
    assign len_clamped = (cmd_dr_len > LEN_W'(DR_W)) ? LEN_W'(DR_W) : cmd_dr_len;
    assign accept      = (state_q == S_IDLE) && cmd_valid && ready_q;
    assign last_half   = (div_q == DIV_W'(HALF_DIV - 1));

    // Flags the final TCK cycle of the current phase.
    always_comb begin
        last_step = 1'b0;
        case (state_q)
            S_TLR:              last_step = (step_q == STEP_W'(5));
            S_IR_NAV:           last_step = (step_q == STEP_W'(3));
            S_IR_SHIFT:         last_step = (step_q == STEP_W'(IR_W - 1));
            S_IR_EXIT:          last_step = (step_q == STEP_W'(1));
            S_DR_NAV:           last_step = (step_q == STEP_W'(2));
            S_DR_SHIFT:         last_step = (step_q == (STEP_W'(len_q) - STEP_W'(1)));
            S_DR_EXIT:          last_step = (step_q == STEP_W'(1));
            S_RTI_WAIT:         last_step = (step_q == STEP_W'(RTI_CYCLES - 1));
            default:            last_step = 1'b0;
        endcase
    end

    // Phase/step that the next TCK cycle belongs to; DR phases are skipped for zero-length payloads.
    always_comb begin
        nxt_state = state_q;
        nxt_step  = step_q + STEP_W'(1);
        if (last_step) begin
            nxt_step = '0;
            case (state_q)
                S_TLR:      nxt_state = S_IR_NAV;
                S_IR_NAV:   nxt_state = S_IR_SHIFT;
                S_IR_SHIFT: nxt_state = S_IR_EXIT;
                S_IR_EXIT:  nxt_state = (len_q != '0) ? S_DR_NAV : POST_DR;
                S_DR_NAV:   nxt_state = S_DR_SHIFT;
                S_DR_SHIFT: nxt_state = S_DR_EXIT;
                S_DR_EXIT:  nxt_state = POST_DR;
                S_RTI_WAIT: nxt_state = S_DONE;
                default:    nxt_state = state_q;
            endcase
        end
    end

    // Sequencer next-state: TCK divider, and TMS/TDI update at the start of every low half.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        div_d       = div_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        en_d        = en_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        ir_d        = ir_q;
        dr_d        = dr_q;
        len_d       = len_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    // First TLR cycle starts on the accept edge itself.
                    state_d = S_TLR;
                    step_d  = '0;
                    div_d   = '0;
                    tck_d   = 1'b0;
                    tms_d   = 1'b1;
                    tdi_d   = 1'b0;
                    en_d    = 1'b1;
                    ready_d = 1'b0;
                    ir_d    = cmd_ir;
                    dr_d    = cmd_dr;
                    len_d   = len_clamped;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                if (!last_half) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    tck_d = ~tck_q;
                    if (tck_q) begin
                        // High half finished: move to the next TCK cycle and drive its TMS/TDI.
                        state_d = nxt_state;
                        step_d  = nxt_step;
                        tdi_d   = 1'b0;
                        case (nxt_state)
                            S_TLR:    tms_d = (nxt_step != STEP_W'(5));
                            S_IR_NAV: tms_d = (nxt_step < STEP_W'(2));
                            S_IR_SHIFT: begin
                                tms_d = (nxt_step == STEP_W'(IR_W - 1));
                                tdi_d = ir_q[0];
                                ir_d  = ir_q >> 1;
                            end
                            S_IR_EXIT, S_DR_NAV, S_DR_EXIT: tms_d = (nxt_step == '0);
                            S_DR_SHIFT: begin
                                tms_d = (nxt_step == (STEP_W'(len_q) - STEP_W'(1)));
                                tdi_d = dr_q[0];
                                dr_d  = dr_q >> 1;
                            end
                            S_RTI_WAIT: tms_d = 1'b0;
                            default: begin
                                // Completion: release the TAP and pulse the response.
                                tck_d       = 1'b0;
                                en_d        = 1'b0;
                                rsp_valid_d = 1'b1;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

`ifdef JTAG_SEQ_TDO_CAPTURE_EN
    logic [DR_W-1:0] cap_q, cap_d;
    logic [DR_W-1:0] mask_q, mask_d;

    // TDO capture: a one-hot mask walks one bit per DR-shift TCK rise; bits past len stay 0.
    always_comb begin
        cap_d  = cap_q;
        mask_d = mask_q;
        if (accept) begin
            cap_d  = '0;
            mask_d = DR_W'(1);
        end else if ((state_q == S_DR_SHIFT) && last_half && !tck_q) begin
            if (tdo_core) begin
                cap_d = cap_q | mask_q;
            end
            mask_d = mask_q << 1;
        end
    end

    assign rsp_dr = cap_q;
`else
    logic unused_tdo;
    assign unused_tdo = tdo_core;
    assign rsp_dr     = '0;
`endif

    // State and registered outputs; srst forces every output to its idle value.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q     <= S_IDLE;
            step_q      <= '0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            en_q        <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            ir_q        <= '0;
            dr_q        <= '0;
            len_q       <= '0;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
            cap_q       <= '0;
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            en_q        <= en_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            ir_q        <= ir_d;
            dr_q        <= dr_d;
            len_q       <= len_d;
`ifdef JTAG_SEQ_TDO_CAPTURE_EN
            cap_q       <= cap_d;
            mask_q      <= mask_d;
`endif
        end
    end

    assign cmd_ready    = ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign jtag_core_en = en_q;
    assign tck_core     = tck_q;
    assign tms_core     = tms_q;
    assign tdi_core     = tdi_q;

endmodule
